// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: streams words into mem, reads them back
// against a running checksum, and on a match issues a one-cycle boot request.
module imem_loader #(
  parameter logic [31:0] BASE  = 32'h0000_0028,
  parameter int          DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic [31:0] address,
  output logic [31:0] memIn,
  output logic        read,
  output logic        write,
  input  logic [31:0] memOut,
  output logic        INT,
  output logic [31:0] entryPoint,
  output logic        done,
  output logic        err,
  output logic [15:0] count
);

  localparam int              IW       = $clog2(DEPTH + 1);
  localparam logic [31:0]     BASE_A   = {BASE[31:2], 2'b00};
  localparam logic [IW-1:0]   LAST_IDX = IW'(DEPTH - 1);
  localparam logic [15:0]     DEPTH16  = 16'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_CMP,
    S_BOOT,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] n_q, n_d;
  logic [31:0]   sumw_q, sumw_d;
  logic [31:0]   sumr_q, sumr_d;
  logic [15:0]   count_q, count_d;
  logic [31:0]   ep_q, ep_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    sumw_d  = sumw_q;
    sumr_d  = sumr_q;
    count_d = count_q;
    ep_d    = ep_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          count_d = '0;
          sumw_d  = '0;
          sumr_d  = '0;
        end
      end
      S_LOAD: begin
        if (s_valid) begin
          idx_d  = idx_q + 1'b1;
          sumw_d = sumw_q + s_data;
          if (count_q != DEPTH16) count_d = count_q + 16'd1;
          if (s_last) begin
            n_d     = idx_q + 1'b1;
            idx_d   = '0;
            state_d = S_VERIFY;
          end else if (idx_q == LAST_IDX) begin
            // Overflowing word is still written; the image is then rejected.
            state_d = S_ERR;
          end
        end
      end
      S_VERIFY: begin
        sumr_d = sumr_q + memOut;
        idx_d  = idx_q + 1'b1;
        if (idx_q == n_q - 1'b1) state_d = S_CMP;
      end
      S_CMP: begin
        if (sumr_q == sumw_q) begin
          state_d = S_BOOT;
          ep_d    = BASE_A;
        end else begin
          state_d = S_ERR;
        end
      end
      S_BOOT:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers need no reset: start clears everything a new load uses.
  always_ff @(posedge clk) begin
    idx_q  <= idx_d;
    n_q    <= n_d;
    sumw_q <= sumw_d;
    sumr_q <= sumr_d;
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      ep_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ep_q    <= ep_d;
    end
  end

  // Outputs are forced low while reset is held so a half-loaded image cannot leak.
  always_comb begin
    s_ready    = (state_q == S_LOAD) && !reset;
    read       = (state_q == S_VERIFY) && !reset;
    write      = s_ready && s_valid;
    address    = (s_ready || read) ? (BASE_A + (32'(idx_q) << 2)) : 32'h0;
    memIn      = s_ready ? s_data : 32'h0;
    INT        = (state_q == S_BOOT) && !reset;
    done       = (state_q == S_DONE) && !reset;
    err        = (state_q == S_ERR) && !reset;
    entryPoint = reset ? 32'h0 : ep_q;
    count      = reset ? 16'h0 : count_q;
  end

endmodule
